// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states,
// the latched request record and the access error check.
package dmem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  // Illegal size, misalignment, or word index past the end of the array.
  function automatic logic acc_err(input logic [1:0] size, input logic [31:0] addr,
                                   input int unsigned depth_words);
    acc_err = (size == 2'b11)
           || (size == SIZE_H && addr[0])
           || (size == SIZE_W && addr[1:0] != 2'b00)
           || ({2'b00, addr[31:2]} >= depth_words);
  endfunction
endpackage

// File: rtl/dmem_responder_align.sv
// Byte-lane steering: store data/byte-enables from size+lane, and load
// lane selection with sign/zero extension.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic        uns,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);
  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign b_sel = raw[{lane, 3'b000} +: 8];
  assign h_sel = lane[1] ? raw[31:16] : raw[15:0];

  // Replicating the right-aligned data across the word lets the byte
  // enables alone pick the destination lane.
  always_comb begin
    be       = 4'b0000;
    wdata_sh = wdata;
    case (size)
      SIZE_B: begin
        be       = 4'b0001 << lane;
        wdata_sh = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
      end
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rdata = raw;
    case (size)
      SIZE_B:  rdata = uns ? {24'b0, b_sel} : {{24{b_sel[7]}}, b_sel};
      SIZE_H:  rdata = uns ? {16'b0, h_sel} : {{16{h_sel[15]}}, h_sel};
      default: rdata = raw;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Accept at edge t, commit (write/read/error check) at edge t+LATENCY.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             accept, commit, err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      raw, wdata_sh, ld_data;
  logic [3:0]       be;
  logic [31:0]      mem [DEPTH_WORDS];

  assign req_ready_o = rst_i && (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign err         = acc_err(req_q.size, req_q.addr, DEPTH_WORDS);
  assign idx         = req_q.addr[IDX_W+1:2];
  assign raw         = mem[idx];

  mem_lane_align u_align (
    .size     (req_q.size),
    .lane     (req_q.addr[1:0]),
    .wdata    (req_q.wdata),
    .uns      (req_q.uns),
    .raw      (raw),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (ld_data)
  );

  // Counter is loaded with LATENCY so even LATENCY=1 spends one edge in WAIT,
  // keeping the commit exactly LATENCY edges after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT;
        cnt_d   = CNT_W'(LATENCY);
        req_d   = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i,
                    size: req_size_i, uns: req_unsigned_i};
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      if (commit) begin
        resp_valid_o <= 1'b1;
        resp_err_o   <= err;
        resp_rdata_o <= (err || req_q.we) ? 32'h0 : ld_data;
      end else if (state_q == RESP && resp_ready_i) begin
        resp_valid_o <= 1'b0;
        resp_rdata_o <= '0;
        resp_err_o   <= 1'b0;
      end
    end
  end

  // Backing array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (commit && req_q.we && !err) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of loads/stores plus
// hand-written back-pressure and mid-transaction reset sequences.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_size  = v.size;
    req_uns   = v.uns;
  endtask

  // Called #1 after an edge; returns edges elapsed until resp_valid seen.
  task automatic wait_resp(output int n);
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (resp_valid !== 1'b1) chk("resp_timeout", 32'(resp_valid), 32'h1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("valid_after_hs", 32'(resp_valid), 32'h0);
    chk("rdata_after_hs", resp_rdata, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int n;
    string tag;
    tag = $sformatf("vec%0d", i);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'h1);
    drive(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(n);
    chk({tag, "_latency"}, 32'(n), LAT);
    chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(resp_err), 32'(v.exp_err));
    handshake();
  endtask

  initial begin
    int n;
    vec_t held;
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0; req_uns = 1'b0;

    //              we    addr          wdata         sz     uns   exp_rdata     err
    vecs.push_back(vec_t'{1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h11,  32'h0,        2'b00, 1'b0, 32'hFFFFFFBE, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h11,  32'h0,        2'b00, 1'b1, 32'h000000BE, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h12,  32'h0,        2'b01, 1'b0, 32'hFFFFDEAD, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b01, 1'b1, 32'h0000BEEF, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h13,  32'hFFFFFF55, 2'b00, 1'b0, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b10, 1'b1, 32'h55ADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h13,  32'h0,        2'b00, 1'b0, 32'h00000055, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h12,  32'h11111111, 2'b10, 1'b0, 32'h0,        1'b1});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h55ADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h11,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h55ADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h10,  32'h22222222, 2'b11, 1'b0, 32'h0,        1'b1});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h55ADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h400, 32'h0,        2'b10, 1'b0, 32'h0,        1'b1});
    vecs.push_back(vec_t'{1'b1, 32'h400, 32'h33333333, 2'b10, 1'b0, 32'h0,        1'b1});
    vecs.push_back(vec_t'{1'b0, 32'h10,  32'h0,        2'b10, 1'b0, 32'h55ADBEEF, 1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h20,  32'hCAFEF00D, 2'b10, 1'b0, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b1, 32'h22,  32'hABCD8001, 2'b01, 1'b0, 32'h0,        1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h20,  32'h0,        2'b10, 1'b0, 32'h8001F00D, 1'b0});
    vecs.push_back(vec_t'{1'b0, 32'h22,  32'h0,        2'b01, 1'b0, 32'hFFFF8001, 1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err",   32'(resp_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(req_ready), 32'h1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-pressure: hold the response while a second request waits.
    @(negedge clk);
    drive(vec_t'{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0});
    req_valid = 1'b1;
    @(posedge clk); #1;
    held = vec_t'{1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0};
    drive(held);
    wait_resp(n);
    chk("hold_latency", 32'(n), LAT);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'h1);
      chk("hold_rdata", resp_rdata, 32'h55ADBEEF);
      chk("hold_err",   32'(resp_err), 32'h0);
      chk("hold_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("hs_valid", 32'(resp_valid), 32'h0);
    chk("hs_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("held_accepted", 32'(req_ready), 32'h0);
    wait_resp(n);
    chk("held_latency", 32'(n), LAT);
    chk("held_rdata", resp_rdata, 32'h8001F00D);
    handshake();

    // Reset during WAIT drops a pending store.
    @(negedge clk);
    drive(vec_t'{1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0});
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wrst_valid", 32'(resp_valid), 32'h0);
    chk("wrst_rdata", resp_rdata, 32'h0);
    chk("wrst_err",   32'(resp_err), 32'h0);
    chk("wrst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("wrst_ready_rel", 32'(req_ready), 32'h1);
    run_vec(vec_t'{1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h8001F00D, 1'b0}, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
